// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding and bit-timing helpers.
// Used by uart_rx and uart_tx so both ends agree on the same baud arithmetic.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_HIGH
    } uart_state_t;

    function automatic int calc_bit_ticks(input int clk_freq, input int baudrate);
        return clk_freq / baudrate;
    endfunction

    function automatic int calc_half_ticks(input int clk_freq, input int baudrate);
        return calc_bit_ticks(clk_freq, baudrate) / 2;
    endfunction

endpackage

// File: rtl/uart_sync.sv
// Multi-bit two-flop synchronizer for slow asynchronous level inputs.
// Resets to all ones so an idle-high line never looks like a start bit.
module uart_sync #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_reg;
    logic [WIDTH-1:0] sync_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_reg <= '1;
            sync_reg <= '1;
        end else begin
            meta_reg <= d;
            sync_reg <= meta_reg;
        end
    end

    assign q = sync_reg;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 1 start, DATA_WIDTH data bits LSB first, 1 stop, centre-sampled.
// Define UART_RX_PARITY_EN to expect an even-parity bit between data and stop.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUDRATE   = 9600,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  line,
    output logic [DATA_WIDTH-1:0] received_data,
    output logic                  valid,
    output logic                  frame_error,
    output logic                  parity_error,
    output logic                  busy
);

    localparam int BIT_TICKS  = calc_bit_ticks(CLK_FREQ, BAUDRATE);
    localparam int HALF_TICKS = calc_half_ticks(CLK_FREQ, BAUDRATE);
    localparam int CNT_W      = $clog2(BIT_TICKS) + 1;
    localparam int IDX_W      = $clog2(DATA_WIDTH);

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_TICKS - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_TICKS - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_WIDTH - 1);

    logic rx_s;

    uart_sync #(
        .WIDTH(1)
    ) u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (line),
        .q    (rx_s)
    );

    uart_state_t           state_reg, state_next;
    logic [CNT_W-1:0]      cnt_reg, cnt_next;
    logic [IDX_W-1:0]      idx_reg, idx_next;
    logic [DATA_WIDTH-1:0] shift_reg, shift_next;
    logic [DATA_WIDTH-1:0] data_reg, data_next;
    logic                  valid_reg, valid_next;
    logic                  ferr_reg, ferr_next;
`ifdef UART_RX_PARITY_EN
    logic                  par_reg, par_next;
    logic                  perr_reg, perr_next;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            idx_reg   <= '0;
            shift_reg <= '0;
            data_reg  <= '0;
            valid_reg <= 1'b0;
            ferr_reg  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_reg   <= 1'b0;
            perr_reg  <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            idx_reg   <= idx_next;
            shift_reg <= shift_next;
            data_reg  <= data_next;
            valid_reg <= valid_next;
            ferr_reg  <= ferr_next;
`ifdef UART_RX_PARITY_EN
            par_reg   <= par_next;
            perr_reg  <= perr_next;
`endif
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        idx_next   = idx_reg;
        shift_next = shift_reg;
        data_next  = data_reg;
        valid_next = 1'b0;
        ferr_next  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_next   = par_reg;
        perr_next  = 1'b0;
`endif
        case (state_reg)
            IDLE: begin
                cnt_next = '0;
                if (!rx_s) begin
                    state_next = START;
                end
            end
            START: begin
                if (cnt_reg == HALF_LAST) begin
                    cnt_next = '0;
                    idx_next = '0;
                    // A start bit that is high again at its centre was a glitch.
                    state_next = rx_s ? IDLE : DATA;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            DATA: begin
                if (cnt_reg == BIT_LAST) begin
                    cnt_next = '0;
                    shift_next[idx_reg] = rx_s;
                    if (idx_reg == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
                        state_next = PARITY;
`else
                        state_next = STOP;
`endif
                    end else begin
                        idx_next = idx_reg + IDX_W'(1);
                    end
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (cnt_reg == BIT_LAST) begin
                    cnt_next   = '0;
                    par_next   = rx_s;
                    state_next = STOP;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
`endif
            STOP: begin
                if (cnt_reg == BIT_LAST) begin
                    cnt_next = '0;
                    if (rx_s) begin
                        // Leave mid stop bit so an immediately following start bit is caught.
                        state_next = IDLE;
`ifdef UART_RX_PARITY_EN
                        if (par_reg != ^shift_reg) begin
                            perr_next = 1'b1;
                        end else begin
                            valid_next = 1'b1;
                            data_next  = shift_reg;
                        end
`else
                        valid_next = 1'b1;
                        data_next  = shift_reg;
`endif
                    end else begin
                        ferr_next  = 1'b1;
                        state_next = WAIT_HIGH;
                    end
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            WAIT_HIGH: begin
                cnt_next = '0;
                if (rx_s) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    assign received_data = data_reg;
    assign valid         = valid_reg;
    assign frame_error   = ferr_reg;
    assign busy          = (state_reg != IDLE);
`ifdef UART_RX_PARITY_EN
    assign parity_error  = perr_reg;
`else
    assign parity_error  = 1'b0;
`endif

endmodule
